// File: rtl/baccarat_hand_pkg.sv
// Shared types, rank constants and card helpers for the baccarat hand datapath.
package baccarat_hand_pkg;

  typedef logic [3:0] card_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_D1,
    S_P2,
    S_D2,
    S_P3,
    S_DONE
  } deal_stage_e;

  localparam card_t MAX_RANK  = 4'd13;
  localparam card_t FACE_MIN  = 4'd10;
  localparam int    NUM_SLOTS = 6;

  // Strobe vector bit order: {dcard3, dcard2, dcard1, pcard3, pcard2, pcard1}
  localparam logic [5:0] STB_P1 = 6'b000001;
  localparam logic [5:0] STB_P2 = 6'b000010;
  localparam logic [5:0] STB_P3 = 6'b000100;
  localparam logic [5:0] STB_D1 = 6'b001000;
  localparam logic [5:0] STB_D2 = 6'b010000;
  localparam logic [5:0] STB_D3 = 6'b100000;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic card_legal(card_t c);
    return (c != 4'd0) && (c <= MAX_RANK);
  endfunction

  function automatic logic [3:0] card_score(card_t c);
    if (c == 4'd0 || c >= FACE_MIN) return 4'd0;
    return c;
  endfunction

  function automatic logic [5:0] allowed_strobes(deal_stage_e st);
    case (st)
      S_IDLE:  return STB_P1;
      S_P1:    return STB_D1;
      S_D1:    return STB_P2;
      S_P2:    return STB_D2;
      S_D2:    return STB_P3 | STB_D3;
      S_P3:    return STB_D3;
      default: return 6'b000000;
    endcase
  endfunction

  // Active-low segments, bit order gfedcba.
  function automatic logic [6:0] card_seg(card_t c);
    case (c)
      4'd1:    return 7'b0001000;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      4'd10:   return 7'b1000000;
      4'd11:   return 7'b1100001;
      4'd12:   return 7'b0011000;
      4'd13:   return 7'b0001001;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/baccarat_hand_datapath_if.sv
// Controller <-> hand datapath bus; HAND_HEX_DISPLAY_EN adds the HEX0..HEX5 displays.
interface baccarat_hand_datapath_if;
  import baccarat_hand_pkg::*;

  // Each load_* is a one-cycle qualifier for new_card sampled on the rising
  // edge; there is no ready, the datapath responds to every strobe that edge.
  card_t       new_card;
  logic        load_pcard1, load_pcard2, load_pcard3;
  logic        load_dcard1, load_dcard2, load_dcard3;
  logic [3:0]  pscore, dscore, pcard3;
  logic [2:0]  cards_dealt;
  logic        protocol_error;
  deal_stage_e stage;
`ifdef HAND_HEX_DISPLAY_EN
  logic [6:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

  modport master (
    output new_card, load_pcard1, load_pcard2, load_pcard3,
           load_dcard1, load_dcard2, load_dcard3,
    input  pscore, dscore, pcard3, cards_dealt, protocol_error, stage,
           HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );
  modport slave (
    input  new_card, load_pcard1, load_pcard2, load_pcard3,
           load_dcard1, load_dcard2, load_dcard3,
    output pscore, dscore, pcard3, cards_dealt, protocol_error, stage,
           HEX0, HEX1, HEX2, HEX3, HEX4, HEX5
  );
`else
  modport master (
    output new_card, load_pcard1, load_pcard2, load_pcard3,
           load_dcard1, load_dcard2, load_dcard3,
    input  pscore, dscore, pcard3, cards_dealt, protocol_error, stage
  );
  modport slave (
    input  new_card, load_pcard1, load_pcard2, load_pcard3,
           load_dcard1, load_dcard2, load_dcard3,
    output pscore, dscore, pcard3, cards_dealt, protocol_error, stage
  );
`endif
endinterface

// File: rtl/hand_score.sv
// Sums the score values of up to three cards of one hand and reduces mod 10.
module hand_score
  import baccarat_hand_pkg::*;
(
  input  card_t      card1,
  input  card_t      card2,
  input  card_t      card3,
  input  logic       valid1,
  input  logic       valid2,
  input  logic       valid3,
  output logic [3:0] score
);

  logic [4:0] sum;

  always_comb begin
    sum = 5'd0;
    if (valid1) sum = sum + {1'b0, card_score(card1)};
    if (valid2) sum = sum + {1'b0, card_score(card2)};
    if (valid3) sum = sum + {1'b0, card_score(card3)};
    // sum never exceeds 27, so at most two subtractions of ten
    if (sum >= 5'd20)      score = 4'(sum - 5'd20);
    else if (sum >= 5'd10) score = 4'(sum - 5'd10);
    else                   score = sum[3:0];
  end

endmodule

// File: rtl/baccarat_hand_datapath.sv
// Hand datapath: latches strobed cards, polices deal order, scores both hands.
// Optional HAND_HEX_DISPLAY_EN drives registered seven-segment card displays.
module baccarat_hand_datapath
  import baccarat_hand_pkg::*;
(
  input  logic                     slow_clock,
  input  logic                     reset,
  baccarat_hand_datapath_if.slave  bus
);

  logic [5:0]              strobes;
  card_t                   cards [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]    valid;
  deal_stage_e             stage;
  deal_stage_e             next_stage;
  logic [2:0]              cards_dealt;
  logic                    protocol_error;
  logic                    any_strobe;
  logic                    strobe_ok;
  card_t                   load_value;

  assign strobes = {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
                    bus.load_pcard3, bus.load_pcard2, bus.load_pcard1};

  always_comb begin
    any_strobe = |strobes;
    strobe_ok  = $onehot(strobes) && (|(strobes & allowed_strobes(stage)));
    load_value = card_legal(bus.new_card) ? bus.new_card : 4'd0;
    case (strobes)
      STB_P1:  next_stage = S_P1;
      STB_D1:  next_stage = S_D1;
      STB_P2:  next_stage = S_P2;
      STB_D2:  next_stage = S_D2;
      STB_P3:  next_stage = S_P3;
      STB_D3:  next_stage = S_DONE;
      default: next_stage = stage;
    endcase
  end

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) cards[i] <= 4'd0;
      valid          <= '0;
      stage          <= S_IDLE;
      cards_dealt    <= 3'd0;
      protocol_error <= 1'b0;
    end else if (any_strobe) begin
      if (strobe_ok) begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (strobes[i]) begin
            cards[i] <= load_value;
            valid[i] <= 1'b1;
          end
        end
        cards_dealt <= cards_dealt + 3'd1;
        stage       <= next_stage;
        // a bad code still consumes the slot but marks the game as faulted
        if (!card_legal(bus.new_card)) protocol_error <= 1'b1;
      end else begin
        protocol_error <= 1'b1;
      end
    end
  end

  hand_score u_player (
    .card1 (cards[0]), .card2 (cards[1]), .card3 (cards[2]),
    .valid1(valid[0]), .valid2(valid[1]), .valid3(valid[2]),
    .score (bus.pscore)
  );

  hand_score u_dealer (
    .card1 (cards[3]), .card2 (cards[4]), .card3 (cards[5]),
    .valid1(valid[3]), .valid2(valid[4]), .valid3(valid[5]),
    .score (bus.dscore)
  );

  assign bus.pcard3         = valid[2] ? card_score(cards[2]) : 4'd0;
  assign bus.cards_dealt    = cards_dealt;
  assign bus.protocol_error = protocol_error;
  assign bus.stage          = stage;

`ifdef HAND_HEX_DISPLAY_EN
  logic [6:0] hex [NUM_SLOTS];

  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) hex[i] <= SEG_BLANK;
    end else if (any_strobe && strobe_ok) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (strobes[i]) hex[i] <= card_seg(load_value);
      end
    end
  end

  assign bus.HEX0 = hex[0];
  assign bus.HEX1 = hex[1];
  assign bus.HEX2 = hex[2];
  assign bus.HEX3 = hex[3];
  assign bus.HEX4 = hex[4];
  assign bus.HEX5 = hex[5];
`endif

endmodule

// File: tb/tb_baccarat_hand_datapath.sv
// Self-checking bench for baccarat_hand_datapath using an expected-result queue.
module tb_baccarat_hand_datapath;
  import baccarat_hand_pkg::*;

  localparam int W = 19;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];

  baccarat_hand_datapath_if bus();

  baccarat_hand_datapath dut (
    .slow_clock(clk),
    .reset     (reset),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] obs;
  assign obs = {bus.pscore, bus.dscore, bus.pcard3, bus.cards_dealt,
                bus.protocol_error, 3'(bus.stage)};

  function automatic logic [W-1:0] ew(int ps, int ds, int p3, int n, int e,
                                      deal_stage_e st);
    return {4'(ps), 4'(ds), 4'(p3), 3'(n), 1'(e), 3'(st)};
  endfunction

  function automatic int model_val(int c);
    return (c >= 10) ? 0 : c;
  endfunction

  // ---------------- drivers ----------------
  task automatic set_strobes(input logic [5:0] stb);
    {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
     bus.load_pcard3, bus.load_pcard2, bus.load_pcard1} = stb;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic deal(input logic [5:0] stb, input logic [3:0] card,
                      input logic [W-1:0] exp);
    exp_q.push_back(exp);
    @(negedge clk);
    set_strobes(stb);
    bus.new_card = card;
    @(posedge clk);
    #1;
    got_q.push_back(obs);
    set_strobes(6'b0);
    bus.new_card = $urandom_range(0, 15);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [W-1:0] e;
    @(negedge clk);
    reset = 1'b1;
    #1;
    exp_q.push_back(ew(0, 0, 0, 0, 0, S_IDLE));
    got_q.push_back(obs);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (got_q.size() == 0) begin
        errors++; $display("FAIL reset step %0d got=none exp=%h", i, e);
      end else if (got_q[0] !== e) begin
        errors++; $display("FAIL reset step %0d got=%h exp=%h", i, got_q[0], e);
      end
      if (got_q.size() > 0) void'(got_q.pop_front());
    end
  endtask

  task automatic deal_four();
    deal(STB_P1, 4'd9,  ew(9, 0, 0, 1, 0, S_P1));
    deal(STB_D1, 4'd12, ew(9, 0, 0, 2, 0, S_D1));
    deal(STB_P2, 4'd5,  ew(4, 0, 0, 3, 0, S_P2));
    deal(STB_D2, 4'd7,  ew(4, 7, 0, 4, 0, S_D2));
  endtask

  task automatic test_normal_deal();
    logic [W-1:0] e, g;
    do_reset();
    deal_four();
    deal(STB_P3, 4'd13, ew(4, 7, 0, 5, 0, S_P3));
    deal(STB_D3, 4'd3,  ew(4, 0, 0, 6, 0, S_DONE));
    deal(STB_D3, 4'd5,  ew(4, 0, 0, 6, 1, S_DONE));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL normal_deal step %0d got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_dealer_third();
    logic [W-1:0] e, g;
    do_reset();
    deal_four();
    deal(STB_D3, 4'd6, ew(4, 3, 0, 5, 0, S_DONE));
    deal(STB_P3, 4'd2, ew(4, 3, 0, 5, 1, S_DONE));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL dealer_third step %0d got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_out_of_order();
    logic [W-1:0] e, g;
    do_reset();
    deal(STB_P1, 4'd9, ew(9, 0, 0, 1, 0, S_P1));
    deal(STB_P2, 4'd4, ew(9, 0, 0, 1, 1, S_P1));
    exp_q.push_back(ew(9, 0, 0, 1, 1, S_P1));
    repeat (10) @(posedge clk);
    #1;
    got_q.push_back(obs);
    do_reset();
    deal(STB_P1, 4'd9, ew(9, 0, 0, 1, 0, S_P1));
    deal(STB_D1 | STB_P2, 4'd4, ew(9, 0, 0, 1, 1, S_P1));
    do_reset();
    deal(STB_D1, 4'd4, ew(0, 0, 0, 0, 1, S_IDLE));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL out_of_order step %0d got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_illegal_card();
    logic [W-1:0] e, g;
    do_reset();
    deal(STB_P1, 4'd0,  ew(0, 0, 0, 1, 1, S_P1));
    deal(STB_D1, 4'd5,  ew(0, 5, 0, 2, 1, S_D1));
    do_reset();
    deal(STB_P1, 4'd14, ew(0, 0, 0, 1, 1, S_P1));
    do_reset();
    deal(STB_P1, 4'd10, ew(0, 0, 0, 1, 0, S_P1));
    deal(STB_D1, 4'd13, ew(0, 0, 0, 2, 0, S_D1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL illegal_card step %0d got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] e, g;
    do_reset();
    deal(STB_P1, 4'd9, ew(9, 0, 0, 1, 0, S_P1));
    deal(STB_D1, 4'd2, ew(9, 2, 0, 2, 0, S_D1));
    deal(STB_P2, 4'd3, ew(2, 2, 0, 3, 0, S_P2));
    #2;
    reset = 1'b1;
    #1;
    exp_q.push_back(ew(0, 0, 0, 0, 0, S_IDLE));
    got_q.push_back(obs);
    @(negedge clk);
    reset = 1'b0;
    deal(STB_P1, 4'd8, ew(8, 0, 0, 1, 0, S_P1));
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL async_reset step %0d got=%h exp=%h", i, g, e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] e, g;
    int c[6];
    int ps, ds, p3;
    logic take_p3;
    for (int game = 0; game < 20; game++) begin
      do_reset();
      for (int k = 0; k < 6; k++) c[k] = $urandom_range(1, 13);
      take_p3 = 1'($urandom_range(0, 1));
      ps = model_val(c[0]);
      deal(STB_P1, 4'(c[0]), ew(ps, 0, 0, 1, 0, S_P1));
      ds = model_val(c[1]);
      deal(STB_D1, 4'(c[1]), ew(ps, ds, 0, 2, 0, S_D1));
      ps = (ps + model_val(c[2])) % 10;
      deal(STB_P2, 4'(c[2]), ew(ps, ds, 0, 3, 0, S_P2));
      ds = (ds + model_val(c[3])) % 10;
      deal(STB_D2, 4'(c[3]), ew(ps, ds, 0, 4, 0, S_D2));
      p3 = 0;
      if (take_p3) begin
        p3 = model_val(c[4]);
        ps = (ps + p3) % 10;
        deal(STB_P3, 4'(c[4]), ew(ps, ds, p3, 5, 0, S_P3));
      end
      ds = (ds + model_val(c[5])) % 10;
      deal(STB_D3, 4'(c[5]), ew(ps, ds, p3, take_p3 ? 6 : 5, 0, S_DONE));
    end
    for (int i = 0; exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g !== e) begin errors++; $display("FAIL back_to_back step %0d got=%h exp=%h", i, g, e); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    bus.new_card = 4'd0;
    set_strobes(6'b0);
    test_reset();
    test_normal_deal();
    test_dealer_third();
    test_out_of_order();
    test_illegal_card();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
